cfg_burst_writer: RTL and testbench
===================================

# cfg_burst_writer

Write-side initiator for the configurable register file. Accepts one burst command (start address, beat count) and a valid/ready data stream, then issues one register write per accepted data beat on the `write_enable`/`write_addr`/`write_data` bus with an auto-incrementing address. It lets a host or DMA front end program the systolic array's configuration registers without driving individual writes cycle by cycle.

## Interface
- `ADDR_WIDTH`, 16, width of the register address bus
- `DATA_WIDTH`, 16, width of register data
- `NUM_REGISTERS`, 8, number of implemented registers; addresses at or above this value are out of range
- `CNT_WIDTH`, 8, width of the burst beat count
- `clk`  in  1  single clock; all logic rises on posedge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  burst command present
- `cmd_ready`  out  1  high only in IDLE
- `cmd_start_addr`  in  ADDR_WIDTH  first register address of the burst
- `cmd_count`  in  CNT_WIDTH  number of beats; 0 is legal
- `data_valid`  in  1  data beat present
- `data_ready`  out  1  high only in BURST
- `data_in`  in  DATA_WIDTH  beat payload
- `write_enable`  out  1  register write strobe, registered
- `write_addr`  out  ADDR_WIDTH  register write address, registered
- `write_data`  out  DATA_WIDTH  register write data, registered
- `busy`  out  1  high in BURST and DONE
- `done`  out  1  one-cycle pulse at end of burst
- `err`  out  1  sticky flag: at least one beat of the current or last burst targeted an out-of-range address

## Operation
- FSM states: IDLE, BURST, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`:
  - latch start address into the address counter and count into the remaining counter;
  - clear `err`;
  - go to BURST if count>0, else DONE.
- BURST: `data_ready`=1. Each handshake (`data_valid` && `data_ready`):
  - registers `write_addr`=address counter and `write_data`=`data_in`;
  - sets `write_enable`=1 for one cycle if address < `NUM_REGISTERS`; otherwise `write_enable`=0 and `err` set;
  - increments the address counter and decrements remaining.
- BURST exit: the handshake that takes remaining from 1 to 0 moves the FSM to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `cmd_ready` and `data_ready` are 0.
- Address counter wraps modulo 2^ADDR_WIDTH. A wrapped address re-enters range and is written normally.
- Out-of-range beats are still consumed; the burst never aborts early.
- `data_valid` gaps in BURST stall the burst without limit. `write_enable` is 0 on every stall cycle.
- `data_valid` outside BURST is ignored and `data_in` is not consumed.
- `cmd_valid` outside IDLE is ignored; the command is not accepted until `cmd_ready`.
- `err` holds its value through IDLE until the next command is accepted.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `data_ready`=0; `write_enable`=0; `write_addr`=0; `write_data`=0; `busy`=0; `done`=0; `err`=0; both counters 0.
- Command accepted at edge k: `busy`=1 and `data_ready`=1 from cycle k+1.
- Data beat accepted at edge n: `write_enable`/`write_addr`/`write_data` valid during cycle n+1.
- Last beat at edge n: during cycle n+1, state=DONE, the last write strobe is visible, and `done`=1. At edge n+2 the FSM is in IDLE with `cmd_ready`=1.
- Zero-count command at edge k: `done`=1 in cycle k+1, `cmd_ready`=1 again in cycle k+2, no writes.
- Throughput: one write per cycle with `data_valid` held high. A burst of N beats occupies N+1 cycles from first `data_ready` to `done`.
- Reset asserted mid-burst:
  - all outputs return to reset values immediately (asynchronous);
  - remaining beats are abandoned and no partial `done` is issued;
  - after reset release the block waits in IDLE.

## Test plan
- Reset, then cmd(start=2, count=3) with data 0xA1,0xA2,0xA3 back-to-back -> writes to addr 2,3,4 on three consecutive cycles, `done` one cycle with the last write, `err`=0.
- cmd(start=6, count=4) on 8 registers -> writes at 6,7; beats for 8,9 consumed with `write_enable`=0; `err`=1 until the next command.
- Gapped data: cmd(start=0, count=2); `data_valid` high, low for 3 cycles, then high -> exactly two strobes, to addr 0 and 1, with no strobe during the gap.
- cmd(count=0) -> `done` the next cycle, no `write_enable`, `cmd_ready` back after 2 cycles; `cmd_valid` held high during DONE is not accepted until IDLE.
- Wrap: `ADDR_WIDTH`=4, `NUM_REGISTERS`=16, cmd(start=15, count=2) -> writes at addr 15 then 0.
- Assert `rst` after 1 of 4 beats -> outputs zero asynchronously, no `done`; a new cmd(start=1, count=1) after release writes addr 1 normally.

Source files
------------

// File: rtl/cfg_burst_writer_if.sv
// Bundle of signals for cfg_burst_writer: burst command, beat stream, register write bus and status.
// The master side issues commands and beats; the slave side (the writer) drives writes and status.
interface cfg_burst_writer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_start_addr;
  logic [CNT_WIDTH-1:0]  cmd_count;

  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data_in;

  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output cmd_valid, cmd_start_addr, cmd_count, data_valid, data_in,
    input  cmd_ready, data_ready, write_enable, write_addr, write_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_start_addr, cmd_count, data_valid, data_in,
    output cmd_ready, data_ready, write_enable, write_addr, write_data, busy, done, err
  );
endinterface

// File: rtl/cfg_burst_writer.sv
// Burst register-write initiator: one write per accepted beat, registered, the cycle after the handshake.
// Beat gaps stall the burst indefinitely; a new command is taken only while idle.
module cfg_burst_writer #(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_REGISTERS = 8,
  parameter int CNT_WIDTH     = 8
) (
  input  logic              clk,
  input  logic              rst,
  cfg_burst_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One extra bit keeps the bound exact when NUM_REGISTERS equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGISTERS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic in_range;
  logic data_fire;

  assign in_range  = {1'b0, addr_q} < NUM_REGS_EXT;
  assign data_fire = (state_q == S_BURST) && bus.data_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d  = bus.cmd_start_addr;
          rem_d   = bus.cmd_count;
          err_d   = 1'b0;
          state_d = (bus.cmd_count != '0) ? S_BURST : S_DONE;
        end
      end

      S_BURST: begin
        if (data_fire) begin
          waddr_d = addr_q;
          wdata_d = bus.data_in;
          // Out-of-range beats are consumed silently and only flag the error.
          if (in_range) begin
            we_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready    = (state_q == S_IDLE);
  assign bus.data_ready   = (state_q == S_BURST);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.write_enable = we_q;
  assign bus.write_addr   = waddr_q;
  assign bus.write_data   = wdata_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_cfg_burst_writer.sv
// Randomized and directed bench for cfg_burst_writer with a write scoreboard and a decoupled monitor.
module tb_cfg_burst_writer;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 8;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  wr_t mon_w;

  cfg_burst_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  cfg_burst_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGISTERS(NR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Narrow instance where the whole address space is in range, so wrap-around writes land.
  cfg_burst_writer_if #(.ADDR_WIDTH(4), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) sbus ();
  cfg_burst_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(DW), .NUM_REGISTERS(16), .CNT_WIDTH(CW)) dut_small (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest expected in-range write.
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0h required=no write t=%0t", bus.write_addr, $time);
      end else begin
        mon_w = sb_q.pop_front();
        chkw("write_addr", 32'(bus.write_addr), 32'(mon_w.addr));
        chkw("write_data", 32'(bus.write_data), 32'(mon_w.data));
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout actual=cmd_ready low required=cmd_ready high t=%0t", $time);
  endtask

  // Reference behaviour: beat i targets (start+i) mod 2^16; in range iff below NR.
  task automatic do_burst(input int start, input int count, input bit fixed_data,
                          input logic [DW-1:0] dbase, input int min_gap, input int max_gap);
    logic [DW-1:0] dq[$];
    bit            inr[$];
    bit            err_exp;
    int            a;
    int            g;
    int            c0;
    logic [DW-1:0] d;
    err_exp = 1'b0;
    for (int i = 0; i < count; i++) begin
      a = (start + i) % 65536;
      d = fixed_data ? DW'(dbase + DW'(i)) : DW'($urandom);
      dq.push_back(d);
      inr.push_back(a < NR);
      if (a < NR) sb_q.push_back('{addr: AW'(a), data: d});
      else        err_exp = 1'b1;
    end

    wait_idle();
    bus.cmd_valid      = 1'b1;
    bus.cmd_start_addr = AW'(start);
    bus.cmd_count      = CW'(count);
    @(posedge clk);
    #1;
    bus.cmd_valid      = 1'b0;
    bus.cmd_start_addr = AW'($urandom);
    bus.cmd_count      = CW'($urandom);
    @(negedge clk);
    chk1("busy_after_cmd", bus.busy, 1'b1);
    chk1("err_cleared_on_cmd", bus.err, 1'b0);
    if (count == 0) begin
      chk1("zero_done", bus.done, 1'b1);
      chk1("zero_no_write", bus.write_enable, 1'b0);
      chk1("zero_no_data_ready", bus.data_ready, 1'b0);
    end else begin
      chk1("data_ready_in_burst", bus.data_ready, 1'b1);
      chk1("no_early_done", bus.done, 1'b0);
      c0 = cyc;
      for (int i = 0; i < count; i++) begin
        g = (i == 0) ? 0 : int'($urandom_range(max_gap, min_gap));
        for (int j = 0; j < g; j++) begin
          bus.data_valid = 1'b0;
          bus.data_in    = DW'($urandom);
          @(negedge clk);
          if (j > 0) chk1("stall_no_write", bus.write_enable, 1'b0);
        end
        bus.data_valid = 1'b1;
        bus.data_in    = dq[i];
        @(negedge clk);
      end
      bus.data_valid = 1'b0;
      chk1("done_pulse", bus.done, 1'b1);
      chk1("last_strobe_with_done", bus.write_enable, inr[count-1]);
      chk1("done_cmd_ready_low", bus.cmd_ready, 1'b0);
      chk1("done_busy", bus.busy, 1'b1);
      chk1("done_err", bus.err, err_exp);
      if (max_gap == 0) chkw("burst_cycles", 32'(cyc - c0), 32'(count));
    end
    @(negedge clk);
    chk1("done_one_cycle", bus.done, 1'b0);
    chk1("idle_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("idle_not_busy", bus.busy, 1'b0);
    chk1("idle_no_write", bus.write_enable, 1'b0);
    chk1("err_held_in_idle", bus.err, err_exp);
    chkw("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    // Beats offered outside BURST must be ignored.
    bus.data_valid = 1'($urandom);
    bus.data_in    = DW'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int c;
    bus.cmd_valid = 1'b0; bus.cmd_start_addr = '0; bus.cmd_count = '0;
    bus.data_valid = 1'b0; bus.data_in = '0;
    sbus.cmd_valid = 1'b0; sbus.cmd_start_addr = '0; sbus.cmd_count = '0;
    sbus.data_valid = 1'b0; sbus.data_in = '0;

    repeat (2) @(negedge clk);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_data_ready", bus.data_ready, 1'b0);
    chk1("rst_write_enable", bus.write_enable, 1'b0);
    chkw("rst_write_addr", 32'(bus.write_addr), 32'd0);
    chkw("rst_write_data", 32'(bus.write_data), 32'd0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk1("rst_err", bus.err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_burst(2, 3, 1'b1, 16'hA1, 0, 0);
    do_burst(6, 4, 1'b0, 16'h0, 0, 0);
    do_burst(0, 2, 1'b0, 16'h0, 3, 3);
    do_burst(65535, 2, 1'b0, 16'h0, 0, 1);

    // Zero-count command, then a different command held through DONE.
    bus.data_valid = 1'b0;
    wait_idle();
    bus.cmd_valid = 1'b1; bus.cmd_start_addr = 16'd0; bus.cmd_count = 8'd0;
    @(posedge clk);
    #1;
    bus.cmd_start_addr = 16'd5; bus.cmd_count = 8'd1;
    sb_q.push_back('{addr: 16'd5, data: 16'h0055});
    @(negedge clk);
    chk1("zc_done", bus.done, 1'b1);
    chk1("zc_cmd_ready_low", bus.cmd_ready, 1'b0);
    chk1("zc_no_write", bus.write_enable, 1'b0);
    @(negedge clk);
    chk1("zc_cmd_ready_back", bus.cmd_ready, 1'b1);
    chk1("zc_not_taken_in_done", bus.busy, 1'b0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk1("held_cmd_busy", bus.busy, 1'b1);
    bus.data_valid = 1'b1; bus.data_in = 16'h0055;
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk1("held_cmd_done", bus.done, 1'b1);
    chk1("held_cmd_strobe", bus.write_enable, 1'b1);

    // Asynchronous reset after the first of four beats (first beat out of range).
    wait_idle();
    bus.cmd_valid = 1'b1; bus.cmd_start_addr = 16'd9; bus.cmd_count = 8'd4;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    bus.data_valid = 1'b1; bus.data_in = 16'h5A5A;
    @(negedge clk);
    bus.data_valid = 1'b0;
    chk1("pre_rst_err", bus.err, 1'b1);
    chkw("pre_rst_write_addr", 32'(bus.write_addr), 32'd9);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("arst_write_enable", bus.write_enable, 1'b0);
    chkw("arst_write_addr", 32'(bus.write_addr), 32'd0);
    chkw("arst_write_data", 32'(bus.write_data), 32'd0);
    chk1("arst_busy", bus.busy, 1'b0);
    chk1("arst_done", bus.done, 1'b0);
    chk1("arst_err", bus.err, 1'b0);
    chk1("arst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("arst_data_ready", bus.data_ready, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("post_rst_no_done", bus.done, 1'b0);
      chk1("post_rst_idle", bus.cmd_ready, 1'b1);
    end
    do_burst(1, 1, 1'b0, 16'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3, 0))
        0:       s = int'($urandom_range(7, 0));
        1:       s = int'($urandom_range(12, 4));
        2:       s = int'($urandom_range(16'hFFFF, 16'hFFFC));
        default: s = int'($urandom_range(16'hFFFF, 0));
      endcase
      c = int'($urandom_range(6, 0));
      do_burst(s, c, 1'b0, 16'h0, 0, int'($urandom_range(3, 0)));
    end

    // Wrap on the 4-bit instance: 15 then 0, both written.
    @(negedge clk);
    sbus.cmd_valid = 1'b1; sbus.cmd_start_addr = 4'd15; sbus.cmd_count = 8'd2;
    @(posedge clk);
    #1 sbus.cmd_valid = 1'b0;
    @(negedge clk);
    sbus.data_valid = 1'b1; sbus.data_in = 16'h1111;
    @(negedge clk);
    chk1("wrap_we0", sbus.write_enable, 1'b1);
    chkw("wrap_addr0", 32'(sbus.write_addr), 32'd15);
    chkw("wrap_data0", 32'(sbus.write_data), 32'h1111);
    sbus.data_in = 16'h2222;
    @(negedge clk);
    sbus.data_valid = 1'b0;
    chk1("wrap_we1", sbus.write_enable, 1'b1);
    chkw("wrap_addr1", 32'(sbus.write_addr), 32'd0);
    chkw("wrap_data1", 32'(sbus.write_data), 32'h2222);
    chk1("wrap_done", sbus.done, 1'b1);
    chk1("wrap_err", sbus.err, 1'b0);

    bus.data_valid = 1'b0;
    repeat (2) @(negedge clk);
    chkw("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
